rtype_sequencer: RTL and testbench
==================================

RTYPE_SEQUENCER -- requirements
Module: rtype_sequencer

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr_valid  input  1  the instruction word is valid.
REQ-005 SHALL have port instr  input  32  RISC-V instruction word.
REQ-006 SHALL have port instr_ready  output  1  the sequencer can accept an instruction.
REQ-007 SHALL have port read_reg1  output  5  datapath rs1 address.
REQ-008 SHALL have port read_reg2  output  5  datapath rs2 address.
REQ-009 SHALL have port write_reg  output  5  datapath rd address.
REQ-010 SHALL have port alu_control  output  4  datapath ALU operation.
REQ-011 SHALL have port write_on_register  output  1  datapath register-file write enable.
REQ-012 SHALL have port zero_flag  input  1  ALU zero result from the datapath.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking instruction completion.
REQ-014 SHALL have port done_zero  output  1  captured zero_flag; valid while done=1.
REQ-015 SHALL have port illegal  output  1  the completing instruction was not a supported R-type; valid while done=1.
REQ-016 SHALL have port retired_count  output  COUNT_W  count of legal instructions completed.

Function
REQ-017 SHALL implement a four-state FSM with states IDLE, DECODE, EXEC and DONE.
REQ-018 IDLE SHALL drive instr_ready=1; all other states SHALL drive instr_ready=0.
REQ-019 A handshake (instr_valid&instr_ready at a rising edge) SHALL latch instr into an internal register and move the FSM to DECODE; without a handshake the FSM SHALL remain in IDLE.
REQ-020 An instruction SHALL be legal only if opcode[6:0]=0110011 and {funct7,funct3} is one of: ADD 0000000/000 ->0010, SUB 0100000/000 ->0110, AND 0000000/111 ->0000, OR 0000000/110 ->0001, XOR 0000000/100 ->0100, SLT 0000000/010 ->0111, SLTU 0000000/011 ->1011, SLL 0000000/001 ->1000, SRL 0000000/101 ->1001, SRA 0100000/101 ->1010.
REQ-021 In DECODE and EXEC, read_reg1, read_reg2, write_reg and alu_control SHALL equal the latched rs1 [19:15], rs2 [24:20], rd [11:7] and the decoded code, held stable across both states.
REQ-022 In IDLE and DONE, read_reg1, read_reg2, write_reg and alu_control SHALL be 0.
REQ-023 DECODE SHALL go to DONE with the illegal flag set for an illegal instruction, and to EXEC otherwise.
REQ-024 EXEC SHALL assert write_on_register for exactly one cycle, suppressed when rd=0; at the end of EXEC the sequencer SHALL capture zero_flag into done_zero and go to DONE.
REQ-025 DONE SHALL assert done for one cycle, increment retired_count for a legal instruction only, and return to IDLE.
REQ-026 Latency: for a handshake at edge t, write_on_register SHALL be high in cycle t+2, done SHALL be high in cycle t+3, and instr_ready SHALL be high again in cycle t+4.
REQ-027 For an illegal instruction, write_on_register SHALL never assert, done_zero SHALL be 0, and done SHALL be high in cycle t+2.
REQ-028 retired_count SHALL wrap from 2^COUNT_W-1 to 0 without a flag.
REQ-029 instr changes while the sequencer is busy SHALL be ignored; exactly one instruction SHALL be in flight at any time.

Reset
REQ-030 reset=0 SHALL immediately force: state IDLE, instr_ready=1, write_on_register=0, done=0, done_zero=0, illegal=0, retired_count=0, all address and alu_control outputs 0, latched instruction 0.
REQ-031 Reset asserted mid-operation SHALL abandon the instruction with no write and no done pulse; after release the FSM SHALL start in IDLE.

Structure
REQ-032 The shared package SHALL hold the 4-bit ALU operation codes, the R-type opcode constant, the funct7 constants and the FSM state typedef.
REQ-033 The natural single sub-module is rtype_decoder: a combinational mapping from instr to {legal, alu_control}, shared by the ALU test bench.

Verification
REQ-034 Test ADD: instr 0x002081B3 -> in DECODE read_reg1=1, read_reg2=2, write_reg=3, alu_control=0010; write_on_register high one cycle; done at t+3 with illegal=0; retired_count=1.
REQ-035 Test SUB: instr 0x407302B3 -> alu_control=0110 with rs1=6, rs2=7, rd=5; with equal register contents, done_zero=1.
REQ-036 Test illegal: instr 0x00100093 (ADDI) -> no write_on_register; done at t+2 with illegal=1; retired_count unchanged.
REQ-037 Test rd=x0: instr 0x00208033 -> write_on_register stays 0; done high; retired_count increments.
REQ-038 Test back-to-back: instr_valid held high with two instructions -> the second is accepted only when instr_ready is high in cycle t+4; exactly two done pulses.
REQ-039 Test reset mid-operation: reset=0 during EXEC -> write_on_register drops the same cycle; no done pulse; IDLE and instr_ready=1 after release.

Source files
------------

// File: rtl/rtype_sequencer_pkg.sv
// Shared constants and types for the R-type instruction sequencer and its decoder.
package rtype_sequencer_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decode: instruction word to {legal, alu_control}.
module rtype_decoder
  import rtype_sequencer_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output logic [3:0]  alu_control
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    legal       = 1'b0;
    alu_control = ALU_AND;
    if (opcode == OPCODE_RTYPE) begin
      case ({funct7, funct3})
        {F7_BASE, 3'b000}: begin legal = 1'b1; alu_control = ALU_ADD;  end
        {F7_ALT,  3'b000}: begin legal = 1'b1; alu_control = ALU_SUB;  end
        {F7_BASE, 3'b111}: begin legal = 1'b1; alu_control = ALU_AND;  end
        {F7_BASE, 3'b110}: begin legal = 1'b1; alu_control = ALU_OR;   end
        {F7_BASE, 3'b100}: begin legal = 1'b1; alu_control = ALU_XOR;  end
        {F7_BASE, 3'b010}: begin legal = 1'b1; alu_control = ALU_SLT;  end
        {F7_BASE, 3'b011}: begin legal = 1'b1; alu_control = ALU_SLTU; end
        {F7_BASE, 3'b001}: begin legal = 1'b1; alu_control = ALU_SLL;  end
        {F7_BASE, 3'b101}: begin legal = 1'b1; alu_control = ALU_SRL;  end
        {F7_ALT,  3'b101}: begin legal = 1'b1; alu_control = ALU_SRA;  end
        default:           begin legal = 1'b0; alu_control = ALU_AND;  end
      endcase
    end
  end

endmodule

// File: rtl/rtype_sequencer.sv
// Four-state sequencer that accepts one R-type instruction at a time and drives
// the datapath register addresses, ALU operation and write enable.
module rtype_sequencer
  import rtype_sequencer_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  output logic [4:0]         read_reg1,
  output logic [4:0]         read_reg2,
  output logic [4:0]         write_reg,
  output logic [3:0]         alu_control,
  output logic               write_on_register,
  input  logic               zero_flag,
  output logic               done,
  output logic               done_zero,
  output logic               illegal,
  output logic [COUNT_W-1:0] retired_count
);

  state_e               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic                 illegal_q, illegal_d;
  logic                 done_zero_q, done_zero_d;
  logic [COUNT_W-1:0]   retired_count_q, retired_count_d;

  logic                 dec_legal;
  logic [3:0]           dec_alu;

  rtype_decoder u_decoder (
    .instr       (instr_q),
    .legal       (dec_legal),
    .alu_control (dec_alu)
  );

  always_comb begin
    state_d           = state_q;
    instr_d           = instr_q;
    illegal_d         = illegal_q;
    done_zero_d       = done_zero_q;
    retired_count_d   = retired_count_q;
    instr_ready       = 1'b0;
    read_reg1         = '0;
    read_reg2         = '0;
    write_reg         = '0;
    alu_control       = '0;
    write_on_register = 1'b0;
    done              = 1'b0;
    done_zero         = 1'b0;
    illegal           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d     = instr;
          illegal_d   = 1'b0;
          done_zero_d = 1'b0;
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        read_reg1   = instr_q[19:15];
        read_reg2   = instr_q[24:20];
        write_reg   = instr_q[11:7];
        alu_control = dec_alu;
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_EXEC: begin
        read_reg1         = instr_q[19:15];
        read_reg2         = instr_q[24:20];
        write_reg         = instr_q[11:7];
        alu_control       = dec_alu;
        // Writes to x0 are architecturally discarded, so never enable them.
        write_on_register = (instr_q[11:7] != 5'd0);
        done_zero_d       = zero_flag;
        state_d           = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        done_zero = done_zero_q;
        illegal   = illegal_q;
        if (!illegal_q) begin
          retired_count_d = retired_count_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      instr_q         <= '0;
      illegal_q       <= 1'b0;
      done_zero_q     <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      illegal_q       <= illegal_d;
      done_zero_q     <= done_zero_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Directed bench for rtype_sequencer; a 2-bit retired counter exercises the wrap.
module tb_rtype_sequencer;

  localparam int COUNT_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               instr_valid;
  logic [31:0]        instr;
  logic               instr_ready;
  logic [4:0]         read_reg1, read_reg2, write_reg;
  logic [3:0]         alu_control;
  logic               write_on_register;
  logic               zero_flag;
  logic               done, done_zero, illegal;
  logic [COUNT_W-1:0] retired_count;

  int n_cmp = 0;
  int n_bad = 0;
  int done_pulses = 0;
  logic [COUNT_W-1:0] exp_count = '0;

  rtype_sequencer #(.COUNT_W(COUNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_ready       (instr_ready),
    .read_reg1         (read_reg1),
    .read_reg2         (read_reg2),
    .write_reg         (write_reg),
    .alu_control       (alu_control),
    .write_on_register (write_on_register),
    .zero_flag         (zero_flag),
    .done              (done),
    .done_zero         (done_zero),
    .illegal           (illegal),
    .retired_count     (retired_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd10, 5'd9, f3, 5'd11, 7'b0110011};
  endfunction

  // One full transaction: handshake at edge t, then check every cycle up to t+4.
  task automatic run_instr(input string tag, input logic [31:0] w, input logic exp_legal,
                           input logic [3:0] exp_alu, input logic [4:0] e_rs1,
                           input logic [4:0] e_rs2, input logic [4:0] e_rd,
                           input logic zf);
    int p0;
    @(negedge clk);
    check({tag, ".ready_before"}, instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = w;
    zero_flag   = zf;
    p0          = done_pulses;
    @(negedge clk);                                   // t+1: DECODE
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    check({tag, ".ready_dec"}, instr_ready, 1'b0);
    check({tag, ".wor_dec"}, write_on_register, 1'b0);
    check({tag, ".rs1_dec"}, read_reg1, e_rs1);
    check({tag, ".rs2_dec"}, read_reg2, e_rs2);
    check({tag, ".rd_dec"}, write_reg, e_rd);
    if (exp_legal) check({tag, ".alu_dec"}, alu_control, exp_alu);
    @(negedge clk);                                   // t+2
    if (exp_legal) begin
      check({tag, ".alu_exec"}, alu_control, exp_alu);
      check({tag, ".rd_exec"}, write_reg, e_rd);
      check({tag, ".wor_exec"}, write_on_register, e_rd != 5'd0);
      check({tag, ".done_exec"}, done, 1'b0);
      @(negedge clk);                                 // t+3
      zero_flag = ~zf;
    end
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".illegal"}, illegal, !exp_legal);
    check({tag, ".done_zero"}, done_zero, exp_legal ? zf : 1'b0);
    check({tag, ".wor_done"}, write_on_register, 1'b0);
    check({tag, ".alu_done"}, alu_control, 4'd0);
    if (exp_legal) exp_count = exp_count + 1'b1;
    @(negedge clk);
    check({tag, ".ready_after"}, instr_ready, 1'b1);
    check({tag, ".count"}, retired_count, exp_count);
    check({tag, ".pulses"}, done_pulses - p0, 1);
  endtask

  initial begin
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    zero_flag   = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst.ready", instr_ready, 1'b1);
    check("rst.wor", write_on_register, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.done_zero", done_zero, 1'b0);
    check("rst.illegal", illegal, 1'b0);
    check("rst.count", retired_count, 2'd0);
    check("rst.regs", {read_reg1, read_reg2, write_reg, alu_control}, 19'd0);
    reset = 1'b1;

    // Idle without handshake stays idle
    repeat (2) @(negedge clk);
    check("idle.ready", instr_ready, 1'b1);
    check("idle.regs", {read_reg1, read_reg2, write_reg, alu_control}, 19'd0);

    run_instr("add",  32'h002081B3, 1'b1, 4'b0010, 5'd1, 5'd2, 5'd3, 1'b0);
    run_instr("sub",  32'h407302B3, 1'b1, 4'b0110, 5'd6, 5'd7, 5'd5, 1'b1);
    run_instr("addi", 32'h00100093, 1'b0, 4'b0000, 5'd0, 5'd1, 5'd1, 1'b1);
    run_instr("x0",   32'h00208033, 1'b1, 4'b0010, 5'd1, 5'd2, 5'd0, 1'b0);

    // Remaining ALU codes; the first of these wraps the 2-bit counter 3 -> 0
    run_instr("or",   rtype(7'b0000000, 3'b110), 1'b1, 4'b0001, 5'd9, 5'd10, 5'd11, 1'b0);
    run_instr("xor",  rtype(7'b0000000, 3'b100), 1'b1, 4'b0100, 5'd9, 5'd10, 5'd11, 1'b1);
    run_instr("slt",  rtype(7'b0000000, 3'b010), 1'b1, 4'b0111, 5'd9, 5'd10, 5'd11, 1'b0);
    run_instr("sltu", rtype(7'b0000000, 3'b011), 1'b1, 4'b1011, 5'd9, 5'd10, 5'd11, 1'b0);
    run_instr("sll",  rtype(7'b0000000, 3'b001), 1'b1, 4'b1000, 5'd9, 5'd10, 5'd11, 1'b0);
    run_instr("srl",  rtype(7'b0000000, 3'b101), 1'b1, 4'b1001, 5'd9, 5'd10, 5'd11, 1'b0);
    run_instr("bad7", rtype(7'b0100000, 3'b111), 1'b0, 4'b0000, 5'd9, 5'd10, 5'd11, 1'b0);
    run_instr("mul",  rtype(7'b0000001, 3'b000), 1'b0, 4'b0000, 5'd9, 5'd10, 5'd11, 1'b0);

    // Back-to-back: AND then SRA with instr_valid held high throughout
    begin
      int p0;
      @(negedge clk);
      p0          = done_pulses;
      zero_flag   = 1'b0;
      instr_valid = 1'b1;
      instr       = 32'h0020F1B3;                     // AND x3,x1,x2
      @(negedge clk);                                 // t+1
      instr = 32'h4020D1B3;                           // SRA x3,x1,x2, waits while busy
      check("b2b.alu_dec1", alu_control, 4'b0000);
      check("b2b.ready_dec1", instr_ready, 1'b0);
      @(negedge clk);                                 // t+2
      check("b2b.alu_exec1", alu_control, 4'b0000);
      check("b2b.wor1", write_on_register, 1'b1);
      @(negedge clk);                                 // t+3
      check("b2b.done1", done, 1'b1);
      check("b2b.ready_done1", instr_ready, 1'b0);
      exp_count = exp_count + 1'b1;
      @(negedge clk);                                 // t+4: second handshake at next edge
      check("b2b.ready_t4", instr_ready, 1'b1);
      check("b2b.count1", retired_count, exp_count);
      @(negedge clk);
      instr_valid = 1'b0;
      check("b2b.alu_dec2", alu_control, 4'b1010);
      @(negedge clk);
      check("b2b.wor2", write_on_register, 1'b1);
      @(negedge clk);
      check("b2b.done2", done, 1'b1);
      exp_count = exp_count + 1'b1;
      repeat (3) @(negedge clk);
      check("b2b.count2", retired_count, exp_count);
      check("b2b.pulses", done_pulses - p0, 2);
    end

    // Reset during EXEC abandons the instruction
    begin
      int p0;
      @(negedge clk);
      p0          = done_pulses;
      instr_valid = 1'b1;
      instr       = 32'h002081B3;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);                                 // EXEC
      check("rmid.wor_exec", write_on_register, 1'b1);
      #1 reset = 1'b0;
      #1;
      check("rmid.wor_drop", write_on_register, 1'b0);
      check("rmid.ready", instr_ready, 1'b1);
      check("rmid.count", retired_count, 2'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("rmid.ready_after", instr_ready, 1'b1);
      check("rmid.no_done", done_pulses - p0, 0);
      check("rmid.regs_after", {read_reg1, read_reg2, write_reg, alu_control}, 19'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
